// File: rtl/teamd_serial_pkg.sv
// Shared definitions for the team's asynchronous serial link (transmitter and receiver rework).
// Optional parity is selected elsewhere with the TEAMD_TX_PARITY_EN macro.
package teamd_serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  localparam int DEFAULT_DATA_BITS = 7;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int count_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/teamd_baud_tick.sv
// Bit-period timer: pulses tick on the last CLK of every CLKS_PER_BIT-cycle bit.
// Independent of TEAMD_TX_PARITY_EN.
module teamd_baud_tick
  import teamd_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic CLK,
  input  logic Reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = count_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  // Wrapping on tick restarts the count for the next bit without a separate clear.
  always_ff @(posedge CLK) begin
    if (Reset || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/teamd_async_serial_tx.sv
// Asynchronous serial transmitter: start bit, LSB-first data, optional even parity, stop bit(s).
// Define TEAMD_TX_PARITY_EN to insert the parity bit; the default build sends no parity.
module teamd_async_serial_tx
  import teamd_serial_pkg::*;
#(
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [DATA_BITS-1:0] iD,
  input  logic                 iSend,
  output logic                 iBusy,
  output logic                 iDone,
  output logic                 Tx
);

  localparam int BIT_W = count_width(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_next;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 tick;
`ifdef TEAMD_TX_PARITY_EN
  logic                 parity;
`endif

  assign shift_next = shift >> 1;

  // Holding the timer clear in IDLE makes every bit start from a zero count.
  teamd_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLK  (CLK),
    .Reset(Reset),
    .clear(state == IDLE),
    .tick (tick)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      Tx      <= IDLE_LEVEL;
      iBusy   <= 1'b0;
      iDone   <= 1'b0;
`ifdef TEAMD_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      iDone <= 1'b0;
      case (state)
        IDLE: begin
          Tx      <= IDLE_LEVEL;
          iBusy   <= 1'b0;
          bit_cnt <= '0;
          if (iSend) begin
            shift <= iD;
`ifdef TEAMD_TX_PARITY_EN
            parity <= ^iD;
`endif
            state <= START;
            Tx    <= START_LEVEL;
            iBusy <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            Tx    <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            shift <= shift_next;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
`ifdef TEAMD_TX_PARITY_EN
              state   <= PARITY;
              Tx      <= parity;
`else
              state   <= STOP;
              Tx      <= STOP_LEVEL;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              Tx      <= shift_next[0];
            end
          end
        end
`ifdef TEAMD_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            Tx    <= STOP_LEVEL;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              state   <= IDLE;
              iBusy   <= 1'b0;
              iDone   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
          Tx      <= IDLE_LEVEL;
          iBusy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/teamd_async_serial_tx.md
Name: teamd_async_serial_tx

Overview:
- Transmit end of the team's asynchronous serial link: serialises a 7-bit parallel word onto a single Tx line.
- Frame is start bit, 7 data bits sent LSB (iD[0]) first, optional parity bit, then stop bit(s).
- Frames are bit-for-bit compatible with the existing shift-register receiver and its control unit. Tx can be looped back to that receiver's Rx for self-test on the pad ring.

Parameters:
- DATA_BITS, 7: data bits per frame; must match the receiver.
- CLKS_PER_BIT, 1: CLK cycles each bit is held; 1 gives the receiver's native rate; legal range 1..256.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- iD  input  DATA_BITS  parallel word; sampled only on an accepted send.
- iSend  input  1  send request; single-cycle or level.
- iBusy  output  1  high while a frame is in flight.
- iDone  output  1  one-cycle pulse when a frame has fully completed.
- Tx  output  1  serial line; idles high.

Behaviour:
- Reset (synchronous, Reset=1 at a rising edge): Tx=1, iBusy=0, iDone=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- Reset mid-frame: Tx returns to 1 on that edge; the frame is aborted with no iDone. The next frame needs a fresh iSend after Reset falls.
- All outputs are registered; there is no combinational path from input to output.
- States: IDLE, START, DATA, [PARITY], STOP.
- IDLE:
  - Tx=1, iBusy=0.
  - iSend=1 at edge k: latch iD into the shift register and go to START.
  - From cycle k+1: Tx=0, iBusy=1.
- Bit timing:
  - Each bit lasts exactly CLKS_PER_BIT cycles, timed by a baud counter that runs 0..CLKS_PER_BIT-1.
  - A bit tick occurs when the counter equals CLKS_PER_BIT-1.
- START: on the tick go to DATA; Tx = shift[0].
- DATA:
  - On each tick, shift right and increment the bit counter.
  - After bit DATA_BITS-1, go to PARITY (if compiled in) or STOP.
- STOP:
  - Tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final tick go to IDLE, iBusy=0, iDone=1 for exactly one cycle.
- Frame length in cycles: (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT, where P=1 with parity and 0 without.
- Back-to-back frames: iSend high in the cycle iDone=1 (first IDLE cycle) is accepted. The next start bit begins on the following cycle, so the inter-frame gap is exactly one CLK of Tx=1 beyond the stop bits.
- iSend while iBusy=1 is ignored; there is no queue. iD changes while busy have no effect.
- Simultaneous Reset and iSend: Reset wins; the send is not accepted.
- Bit and baud counters saturate at no value. Both are cleared on every state transition, so there is no wrap-around across frames.

Optional Feature:
- Macro: TEAMD_TX_PARITY_EN.
- Defined: a PARITY state after the data bits sends even parity (XOR of the latched word) for CLKS_PER_BIT cycles. The frame grows by one bit.
- Undefined: the PARITY state and its logic are absent; DATA goes directly to STOP. This matches the current receiver, which expects no parity.

Decomposition:
- Shared package teamd_serial_pkg contains:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - constants IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1, DEFAULT_DATA_BITS=7.
- The receiver-side rework will reuse this package.
- Sub-module teamd_baud_tick:
  - parameterised by CLKS_PER_BIT; inputs CLK, Reset, clear; output tick;
  - counter width max(1, clog2(CLKS_PER_BIT)).

Test Plan:
- Basic frame: CLKS_PER_BIT=1, iD=7'b1010011, iSend pulse at cycle 0 -> Tx over cycles 1..9 = 0,1,1,0,0,1,0,1,1. iBusy=1 for cycles 1..9; iDone=1 at cycle 10 only.
- Slow rate: CLKS_PER_BIT=4, iD=7'h55 -> each Tx level held exactly 4 cycles. iBusy high for 36 cycles; iDone one cycle after.
- Back-to-back and busy rejection: iSend held high with iD=7'h7F then iD=7'h00 presented at iDone -> second frame starts the next cycle with start bit 0. An iSend pulse mid-frame changes nothing.
- Reset mid-frame: Reset=1 at the 4th data bit -> Tx=1, iBusy=0 on the next edge; no iDone; the following iSend produces a clean full frame.
- Loopback: Tx wired to the receiver's Rx on the shared clock, 20 random words -> the receiver's iD0..iD6 equal the sent word whenever its iLoad asserts.
- Parity (TEAMD_TX_PARITY_EN defined): iD=7'b1010011 (four ones) -> parity bit 0 at cycle 9, stop at cycle 10. iD=7'b0000001 -> parity bit 1.
